alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Multi-cycle control unit that sequences one ALU operation over the single shared datapath bus. Per operation it:
- moves operand A into Y;
- drives operand B plus the one-hot ALU op so the result is captured in Z;
- writes ZLO to the destination register, or to LO and HI for multiply/divide.

It sits between the instruction control FSM, which issues start/opcode/register indices, and the bus strobes of the register file, Y, Z, HI and LO.

Parameters:
MUL_CYC, 2, cycles the ALU op is held in RB phase for multiply (Zin on last cycle); must be ≥1
DIV_CYC, 4, same for divide; must be ≥1
OTHER_CYC, 1, same for all other ops; must be ≥1

Ports:
clock  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when busy=0
opcode  in  4  0 add,1 sub,2 shr,3 shl,4 ror,5 rol,6 and,7 or,8 mul,9 div,10 neg,11 not,12-15 illegal
ra_idx  in  4  operand A register
rb_idx  in  4  operand B register
rd_idx  in  4  destination register
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse at completion
err  out  1  one-cycle pulse with done for illegal opcode
alu_ctrl  out  12  one-hot {not,neg,div,mul,or,and,rol,ror,shl,shr,sub,add}; zero when not in RB
rf_sel  out  4  register index addressed on this cycle
rf_out  out  1  selected register drives bus
rf_in  out  1  selected register loads from bus
y_in  out  1  Y loads bus
z_in  out  1  Z (ZHI/ZLO) loads ALU result
zlo_out  out  1  ZLO drives bus
zhi_out  out  1  ZHI drives bus
lo_in  out  1  LO loads bus
hi_in  out  1  HI loads bus

Behaviour:
- Reset (clear_n=0, asynchronous):
  - state=IDLE; all outputs 0; latched opcode/indices=0; counter=0.
  - Reset mid-operation aborts the operation; no done is produced.
- Outputs are decoded from registered state and latched fields only, with no combinational path from inputs.
- Handshake:
  - IDLE samples start on the clock edge, latching opcode and the three indices.
  - start while busy=1 is ignored; the latched fields are not disturbed.
- States:
  - IDLE → RA when start and the opcode is binary (0-9).
  - IDLE → RB for unary ops (10, 11); Y is not loaded.
  - IDLE → DONE for opcodes 12-15.
  - RA, 1 cycle: rf_sel=ra_idx, rf_out=1, y_in=1.
  - RB, N cycles: rf_sel=rb_idx, rf_out=1, alu_ctrl=decoded op, z_in=1 on the last cycle only.
    - N=MUL_CYC for mul, DIV_CYC for div, OTHER_CYC otherwise.
    - The counter loads N-1 on entry, decrements each cycle, and the state exits when the counter is 0.
  - RB → LO.
  - LO, 1 cycle: zlo_out=1.
    - mul/div: lo_in=1, then → HI.
    - All other ops: rf_sel=rd_idx, rf_in=1, then → DONE.
  - HI, 1 cycle: zhi_out=1, hi_in=1, → DONE.
  - DONE, 1 cycle: done=1; err=1 if the opcode was illegal. → IDLE.
- A new start is accepted in IDLE the cycle after DONE, so back-to-back ops have a 1-cycle gap.
- Exactly one bus driver (rf_out, zlo_out, zhi_out) is high in any cycle; none is high in IDLE/DONE.
- alu_ctrl has at most one bit set; bit position = opcode.
- Latency from the start-accept edge to done high:
  - add: RA, RB, LO, DONE → done on cycle 4.
  - mul with MUL_CYC=2: RA, RB×2, LO, HI, DONE → cycle 6.
  - div with DIV_CYC=4: cycle 8.
  - not: RB, LO, DONE → cycle 3.
  - illegal: cycle 1.

Test Plan:
- Reset then add (opcode 0, ra=2, rb=3, rd=5), start 1 cycle → RA: rf_sel=2, y_in; RB: rf_sel=3, alu_ctrl=12'h001, z_in; LO: zlo_out, rf_sel=5, rf_in; done on cycle 4; busy cycles 1-4.
- mul (opcode 8), MUL_CYC=2 → alu_ctrl=12'h100 for 2 cycles with z_in only on the 2nd; lo_in then zhi_out+hi_in; done on cycle 6; rf_in never asserted.
- div with DIV_CYC=4; start re-pulsed with opcode 0 during RB → ignored; the running op still reports alu_ctrl=12'h200 and completes with done on cycle 8.
- not (opcode 11, rb=7, rd=1) → no y_in cycle; RB alu_ctrl=12'h800; done on cycle 3.
- opcode 13 → done=1, err=1 on cycle 1; no bus or load strobes at any time.
- clear_n low during the 2nd RB cycle of div → all outputs 0 immediately (asynchronously); after release, IDLE and no done; a following add completes normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control unit that steps one ALU operation
// across the shared datapath bus. Each operation moves A into Y, then B
// through the ALU into Z, then writes ZLO back to a register. Multiply and
// divide write ZLO to LO and ZHI to HI instead. All strobes are decoded from
// registered state and latched fields, so no input reaches an output
// combinationally.
module alu_sequencer #(
  parameter int unsigned MUL_CYC   = 2,
  parameter int unsigned DIV_CYC   = 4,
  parameter int unsigned OTHER_CYC = 1
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [3:0]  ra_idx,
  input  logic [3:0]  rb_idx,
  input  logic [3:0]  rd_idx,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [11:0] alu_ctrl,
  output logic [3:0]  rf_sel,
  output logic        rf_out,
  output logic        rf_in,
  output logic        y_in,
  output logic        z_in,
  output logic        zlo_out,
  output logic        zhi_out,
  output logic        lo_in,
  output logic        hi_in
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RA   = 3'd1;
  localparam logic [2:0] S_RB   = 3'd2;
  localparam logic [2:0] S_LO   = 3'd3;
  localparam logic [2:0] S_HI   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_NEG = 4'd10;

  logic [2:0] state_q, state_d;
  logic [3:0] op_q, ra_q, rb_q, rd_q;
  logic [7:0] cnt_q, cnt_d;
  logic       accept;
  logic       is_muldiv;

  // Value loaded into the RB-phase counter: hold cycles minus one.
  function automatic logic [7:0] rb_last(input logic [3:0] op);
    case (op)
      OP_MUL:  return 8'(MUL_CYC - 1);
      OP_DIV:  return 8'(DIV_CYC - 1);
      default: return 8'(OTHER_CYC - 1);
    endcase
  endfunction

  assign accept    = (state_q == S_IDLE) && start;
  assign is_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);

  // Next-state and RB-counter control.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (opcode < OP_NEG) begin
            state_d = S_RA;
          end else if (opcode < 4'd12) begin
            state_d = S_RB;
            cnt_d   = rb_last(opcode);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RA: begin
        state_d = S_RB;
        cnt_d   = rb_last(op_q);
      end
      S_RB: begin
        if (cnt_q == 8'd0) state_d = S_LO;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_LO:    state_d = is_muldiv ? S_HI : S_DONE;
      S_HI:    state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and the operation fields latched when start is accepted.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      op_q    <= 4'd0;
      ra_q    <= 4'd0;
      rb_q    <= 4'd0;
      rd_q    <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before the edge.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q <= opcode;
        ra_q <= ra_idx;
        rb_q <= rb_idx;
        rd_q <= rd_idx;
      end
    end
  end

  // Bus and load strobes decoded from the registered state.
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = 1'b0;
    err      = 1'b0;
    alu_ctrl = 12'h000;
    rf_sel   = 4'd0;
    rf_out   = 1'b0;
    rf_in    = 1'b0;
    y_in     = 1'b0;
    z_in     = 1'b0;
    zlo_out  = 1'b0;
    zhi_out  = 1'b0;
    lo_in    = 1'b0;
    hi_in    = 1'b0;
    case (state_q)
      S_RA: begin
        rf_sel = ra_q;
        rf_out = 1'b1;
        y_in   = 1'b1;
      end
      S_RB: begin
        rf_sel   = rb_q;
        rf_out   = 1'b1;
        alu_ctrl = 12'h001 << op_q;
        z_in     = (cnt_q == 8'd0);
      end
      S_LO: begin
        zlo_out = 1'b1;
        if (is_muldiv) begin
          lo_in = 1'b1;
        end else begin
          rf_sel = rd_q;
          rf_in  = 1'b1;
        end
      end
      S_HI: begin
        zhi_out = 1'b1;
        hi_in   = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        err  = (op_q >= 4'd12);
      end
      default: ;
    endcase
  end

endmodule
